// File: rtl/if_prefetch_pkg.sv
// if_prefetch_pkg: shared constants and fetch FSM encoding for the instruction-fetch front end
package if_prefetch_pkg;
    localparam logic [15:0] DEF_NOP_INST = 16'h0000;
    localparam logic [15:0] DEF_RESET_PC = 16'h0000;
    typedef enum logic [1:0] {
        IF_IDLE  = 2'd0,
        IF_REQ   = 2'd1,
        IF_DRAIN = 2'd2
    } if_state_t;
endpackage

// File: rtl/if_prefetch_fetch_fifo.sv
// fetch_fifo: small prefetch queue of {inst, pc+1} words with flush
module fetch_fifo
    import if_prefetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           push,
    input  logic                           pop,
    input  logic [31:0]                    din,
    output logic [31:0]                    dout,
    output logic [$clog2(DEPTH+1)-1:0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wp, rp;
    assign dout = mem[rp];
    // pointer and occupancy bookkeeping; a flush discards everything queued
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= wp + AW'(push);
            rp    <= rp + AW'(pop);
            count <= count + CW'(push) - CW'(pop);
        end
    end
    // storage needs no reset: entries are only read behind a non-zero count
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wp] <= din;
    end
endmodule

// File: rtl/if_prefetch.sv
// if_prefetch: fetch PC, single-outstanding imem requests, prefetch FIFO and IF/ID output register
module if_prefetch
    import if_prefetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = DEF_RESET_PC,
    parameter logic [15:0] NOP_INST = DEF_NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        stall,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [15:0] inst_out,
    output logic [15:0] pc_plus_one_out,
    output logic        inst_valid
);
    localparam int CW = $clog2(DEPTH + 1);
    if_state_t     state, state_nxt;
    logic [15:0]   fpc, fpc_nxt, fpc_inc, req_addr;
    logic [CW-1:0] count;
    logic [31:0]   head;
    logic          push, pop;
    assign fpc_inc   = fpc + 16'd1;
    assign push      = state == IF_REQ && imem_ack && !redirect;
    assign pop       = !redirect && !stall && count != '0;
    assign imem_req  = state != IF_IDLE;
    assign imem_addr = req_addr;
    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect),
        .push  (push),
        .pop   (pop),
        .din   ({imem_rdata, fpc_inc}),
        .dout  (head),
        .count (count)
    );
    // next fetch state and PC; a stale request keeps its address until it completes
    always_comb begin
        state_nxt = state;
        fpc_nxt   = redirect ? redirect_pc : fpc;
        case (state)
            IF_IDLE: if (redirect || int'(count) < DEPTH) state_nxt = IF_REQ;
            IF_REQ: begin
                if (imem_ack && !redirect) begin
                    fpc_nxt = fpc_inc;
                    if (!(int'(count) < DEPTH - 1 || pop)) state_nxt = IF_IDLE;
                end else if (!imem_ack && redirect) begin
                    state_nxt = IF_DRAIN;
                end
            end
            IF_DRAIN: if (imem_ack) state_nxt = IF_REQ;
            default: state_nxt = IF_IDLE;
        endcase
    end
    // fetch state, PC and the request address presented to memory
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IF_IDLE;
            fpc      <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            state <= state_nxt;
            fpc   <= fpc_nxt;
            if (state == IF_IDLE || imem_ack) req_addr <= fpc_nxt;
        end
    end
    // IF/ID output register: redirect clears, stall holds, otherwise load head or bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_out        <= NOP_INST;
            pc_plus_one_out <= '0;
            inst_valid      <= 1'b0;
        end else if (redirect) begin
            inst_out   <= NOP_INST;
            inst_valid <= 1'b0;
        end else if (!stall) begin
            inst_out        <= pop ? head[31:16] : NOP_INST;
            pc_plus_one_out <= pop ? head[15:0] : pc_plus_one_out;
            inst_valid      <= pop;
        end
    end
endmodule

// File: tb/tb_if_prefetch.sv
// tb_if_prefetch: vector table, corner sequences and randomized stream scoreboard for if_prefetch
module tb_if_prefetch;
    logic        clk = 1'b0, rst = 1'b1, redirect = 1'b0, stall = 1'b0, imem_ack = 1'b0;
    logic [15:0] redirect_pc = 16'h0, imem_rdata = 16'h0;
    logic        imem_req, inst_valid;
    logic [15:0] imem_addr, inst_out, pc_plus_one_out;
    int          n_cmp = 0, n_bad = 0, loads = 0, wcnt = 0, cur_lat = 0, lat = 0;
    logic        rand_lat = 1'b0;
    logic [15:0] exp_addr = 16'h0;

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [15:0] rpc;
        logic        req;
        logic [15:0] addr;
        logic [15:0] inst;
        logic [15:0] pcp1;
        logic        valid;
    } vec_t;
    vec_t vecs[17];

    always #5 clk = ~clk;

    if_prefetch dut (
        .clk             (clk),
        .rst             (rst),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .stall           (stall),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .inst_out        (inst_out),
        .pc_plus_one_out (pc_plus_one_out),
        .inst_valid      (inst_valid)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock: check the stream model for the cycle that just ended, then answer memory.
    // Expected stream: after reset or a redirect to P, valid words are mem[P], mem[P+1], ...
    // with mem[a] = 16'h1000 + a and pc_plus_one = a + 1.
    task automatic tick();
        logic        p_red, p_stall, p_req, p_ack, p_valid, p_rst;
        logic [15:0] p_rpc, p_addr, p_inst, p_pcp1;
        p_red = redirect; p_stall = stall; p_req = imem_req; p_ack = imem_ack;
        p_valid = inst_valid; p_rst = rst; p_rpc = redirect_pc; p_addr = imem_addr;
        p_inst = inst_out; p_pcp1 = pc_plus_one_out;
        @(posedge clk);
        #1;
        if (!p_rst && !rst) begin
            if (p_req && !p_ack)
                check("addr_hold", 64'({imem_req, imem_addr}), 64'({1'b1, p_addr}));
            if (p_red) begin
                check("redirect_out", 64'({inst_valid, inst_out, pc_plus_one_out}), 64'({1'b0, 16'h0000, p_pcp1}));
                exp_addr = p_rpc;
            end else if (p_stall) begin
                check("stall_hold", 64'({inst_valid, inst_out, pc_plus_one_out}), 64'({p_valid, p_inst, p_pcp1}));
            end else if (inst_valid) begin
                check("stream_word", 64'({inst_out, pc_plus_one_out}), 64'({16'h1000 + exp_addr, exp_addr + 16'd1}));
                exp_addr++;
                loads++;
            end else begin
                check("bubble_out", 64'({inst_out, pc_plus_one_out}), 64'({16'h0000, p_pcp1}));
            end
        end
        if (rst) begin
            imem_ack = 1'b0;
            wcnt = 0;
        end else begin
            if (p_ack) wcnt = 0;
            if (imem_req) begin
                if (wcnt == 0) cur_lat = rand_lat ? int'($urandom_range(0, 3)) : lat;
                imem_ack = wcnt >= cur_lat;
                wcnt++;
            end else begin
                imem_ack = 1'b0;
                wcnt = 0;
            end
            imem_rdata = 16'h1000 + imem_addr;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect = 1'b0; stall = 1'b0; imem_ack = 1'b0; wcnt = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_addr = 16'h0;
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!inst_valid && n < 60) begin
            tick();
            n++;
        end
        check(nm, 64'(inst_valid), 64'(1'b1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0001, 16'h0000, 16'h0000, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0002, 16'h1000, 16'h0001, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0003, 16'h1001, 16'h0002, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0004, 16'h1001, 16'h0002, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0005, 16'h1001, 16'h0002, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0006, 16'h1001, 16'h0002, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0006, 16'h1002, 16'h0003, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0006, 16'h1003, 16'h0004, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0007, 16'h1004, 16'h0005, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 16'h0040, 1'b1, 16'h0040, 16'h0000, 16'h0005, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0041, 16'h0000, 16'h0005, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0042, 16'h1040, 16'h0041, 1'b1};
        vecs[13] = '{1'b1, 1'b1, 16'hFFFF, 1'b1, 16'hFFFF, 16'h0000, 16'h0041, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0000, 16'h0041, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0001, 16'h0FFF, 16'h0000, 1'b1};
        vecs[16] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0002, 16'h1000, 16'h0001, 1'b1};

        // reset values, then zero-wait table: startup, stall fill, redirects, wrap
        do_reset();
        check("reset_vals", 64'({imem_req, imem_addr, inst_out, pc_plus_one_out, inst_valid}),
              64'({1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0}));
        lat = 0;
        for (int i = 0; i < 17; i++) begin
            stall = vecs[i].stall;
            redirect = vecs[i].redirect;
            redirect_pc = vecs[i].rpc;
            tick();
            check($sformatf("vec%0d", i), 64'({imem_req, imem_addr, inst_out, pc_plus_one_out, inst_valid}),
                  64'({vecs[i].req, vecs[i].addr, vecs[i].inst, vecs[i].pcp1, vecs[i].valid}));
        end
        redirect = 1'b0;
        stall = 1'b0;

        // 2-wait memory with a long stall: FIFO fills, requests stop, then drains back-to-back
        do_reset();
        lat = 2;
        wait_valid("fill_first_valid");
        stall = 1'b1;
        begin
            int n = 0;
            while (imem_req && n < 60) begin
                tick();
                n++;
            end
        end
        check("fill_idle", 64'(imem_req), 64'(1'b0));
        repeat (2) tick();
        stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("burst_valid%0d", i), 64'(inst_valid), 64'(1'b1));
        end

        // redirect while a 3-wait request to address 5 is outstanding
        do_reset();
        lat = 3;
        begin
            int n = 0;
            while (!(imem_req && imem_addr == 16'h0005 && !imem_ack) && n < 100) begin
                tick();
                n++;
            end
        end
        check("reach_addr5", 64'({imem_req, imem_addr}), 64'({1'b1, 16'h0005}));
        redirect = 1'b1;
        redirect_pc = 16'h0040;
        tick();
        redirect = 1'b0;
        check("drain_addr", 64'({imem_req, imem_addr}), 64'({1'b1, 16'h0005}));
        begin
            int n = 0;
            while (!imem_ack && n < 10) begin
                tick();
                n++;
            end
        end
        tick();
        check("after_drain_addr", 64'({imem_req, imem_addr}), 64'({1'b1, 16'h0040}));
        wait_valid("redirect_first_valid");
        check("redirect_first_word", 64'({inst_out, pc_plus_one_out}), 64'({16'h1040, 16'h0041}));

        // asynchronous reset mid-request, then a stray ack right after release
        do_reset();
        lat = 1;
        wait_valid("pre_rst_valid");
        begin
            int n = 0;
            while (!(imem_req && !imem_ack) && n < 10) begin
                tick();
                n++;
            end
        end
        rst = 1'b1;
        #1;
        check("async_rst", 64'({imem_req, imem_addr, inst_out, pc_plus_one_out, inst_valid}),
              64'({1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0}));
        imem_ack = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_addr = 16'h0;
        wcnt = 0;
        imem_ack = 1'b1;
        imem_rdata = 16'hDEAD;
        tick();
        check("stray_ack_req", 64'({imem_req, imem_addr}), 64'({1'b1, 16'h0000}));
        wait_valid("post_rst_valid");
        check("post_rst_first", 64'({inst_out, pc_plus_one_out}), 64'({16'h1000, 16'h0001}));

        // randomized stall/redirect/latency against the stream model
        do_reset();
        rand_lat = 1'b1;
        loads = 0;
        for (int i = 0; i < 3000; i++) begin
            stall = $urandom_range(0, 99) < 30;
            redirect = $urandom_range(0, 99) < 5;
            redirect_pc = ($urandom_range(0, 7) == 0) ? 16'hFFFE : 16'($urandom);
            tick();
        end
        redirect = 1'b0;
        stall = 1'b0;
        check("rand_throughput", 64'(loads > 100), 64'(1'b1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
